// File: rtl/mem_stage_ctrl_if.sv
// EX/MEM memory-control fields and the data-memory request/ready channel.
// slave = the MEM-stage sequencer; master = the pipeline/memory side driving it.
interface mem_stage_ctrl_if;
   logic        MemRead_in;
   logic        MemWrite_in;
   logic [1:0]  BHW_in;
   logic        DataMemExtendSign_in;
   logic [31:0] Addr_in;
   logic [31:0] WriteData_in;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] ReadData_out;
   logic        Stall_out;
   logic        Fault_out;

   modport slave (
      input  MemRead_in, MemWrite_in, BHW_in, DataMemExtendSign_in, Addr_in, WriteData_in,
      input  mem_ready, mem_rdata,
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata, ReadData_out, Stall_out, Fault_out
   );

   modport master (
      output MemRead_in, MemWrite_in, BHW_in, DataMemExtendSign_in, Addr_in, WriteData_in,
      output mem_ready, mem_rdata,
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata, ReadData_out, Stall_out, Fault_out
   );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory sequencer: one req/ready access per load/store, byte/half/word lanes, load extension.
// Stalls from the request cycle until mem_ready (min 1 cycle); misaligned/illegal/timeout end in a 1-cycle Fault pulse.
module mem_stage_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic             clk,
   input  logic             rst,
   mem_stage_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_FAULT} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;

   logic        is_half, is_byte, pending, illegal, misaligned;
   logic        req, stall, fault;
   logic [3:0]  be_raw;
   logic [31:0] wdata_raw, load_ext;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign is_half    = (bus.BHW_in == 2'b01);
   assign is_byte    = (bus.BHW_in == 2'b10);
   assign pending    = bus.MemRead_in | bus.MemWrite_in;
   assign illegal    = bus.MemRead_in & bus.MemWrite_in;
   assign misaligned = is_half ? bus.Addr_in[0] : (!is_byte && bus.Addr_in[1:0] != 2'b00);

   // Little-endian lanes: byte at offset n lives in bits 8n+7:8n.
   assign ld_byte = bus.mem_rdata[{bus.Addr_in[1:0], 3'b000} +: 8];
   assign ld_half = bus.mem_rdata[{bus.Addr_in[1], 4'b0000} +: 16];

   always_comb begin
      be_raw    = 4'hF;
      wdata_raw = bus.WriteData_in;
      load_ext  = bus.mem_rdata;
      if (is_byte) begin
         be_raw    = 4'b0001 << bus.Addr_in[1:0];
         wdata_raw = {4{bus.WriteData_in[7:0]}};
         load_ext  = {{24{bus.DataMemExtendSign_in & ld_byte[7]}}, ld_byte};
      end else if (is_half) begin
         be_raw    = bus.Addr_in[1] ? 4'b1100 : 4'b0011;
         wdata_raw = {2{bus.WriteData_in[15:0]}};
         load_ext  = {{16{bus.DataMemExtendSign_in & ld_half[15]}}, ld_half};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      req     = 1'b0;
      stall   = 1'b0;
      fault   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pending) begin
               stall = 1'b1;
               if (illegal || misaligned) begin
                  state_d = S_FAULT;
                  rdata_d = '0;
               end else begin
                  req = 1'b1;
                  if (bus.mem_ready) begin
                     state_d = S_DONE;
                     if (bus.MemRead_in) rdata_d = load_ext;
                  end else begin
                     state_d = S_WAIT;
                     cnt_d   = '0;
                  end
               end
            end
         end
         S_WAIT: begin
            req   = 1'b1;
            stall = 1'b1;
            if (bus.mem_ready) begin
               state_d = S_DONE;
               if (bus.MemRead_in) rdata_d = load_ext;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_FAULT;
               rdata_d = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_FAULT: begin
            fault   = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
      end
   end

   // Reset forces every combinational output low, abandoning any request in flight.
   assign bus.mem_req      = req & ~rst;
   assign bus.mem_we       = req & bus.MemWrite_in & ~rst;
   assign bus.Stall_out    = stall & ~rst;
   assign bus.Fault_out    = fault & ~rst;
   assign bus.mem_addr     = rst ? 32'd0 : {bus.Addr_in[31:2], 2'b00};
   assign bus.mem_be       = (rst || !pending) ? 4'd0 : be_raw;
   assign bus.mem_wdata    = rst ? 32'd0 : wdata_raw;
   assign bus.ReadData_out = rdata_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl with TIMEOUT_CYCLES=4: directed cases plus random accesses
// scored against a per-transaction reference model built from byte-lane arithmetic.
module tb_mem_stage_ctrl;
   localparam int T = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;
   logic [31:0] model_rd = 32'd0;

   mem_stage_ctrl_if bus();

   mem_stage_ctrl #(.TIMEOUT_CYCLES(T)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] bhw);
      case (bhw)
         2'b01:   return 2;
         2'b10:   return 1;
         default: return 4;
      endcase
   endfunction

   function automatic int lane_of(input logic [1:0] bhw, input logic [31:0] addr);
      int n = nbytes(bhw);
      int off = int'(addr % 4);
      return off - (off % n);
   endfunction

   function automatic logic [3:0] m_be(input logic [1:0] bhw, input logic [31:0] addr);
      int n = nbytes(bhw);
      return 4'(((1 << n) - 1) << lane_of(bhw, addr));
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] bhw, input logic [31:0] wd);
      int n = nbytes(bhw);
      if (n == 1) return (wd & 32'hFF) * 32'h01010101;
      if (n == 2) return (wd & 32'hFFFF) * 32'h00010001;
      return wd;
   endfunction

   function automatic logic [31:0] m_load(input logic [1:0] bhw, input logic [31:0] addr,
                                          input logic sgn, input logic [31:0] rdata);
      int n = nbytes(bhw);
      logic [31:0] mask, v;
      mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
      v = (rdata >> (8 * lane_of(bhw, addr))) & mask;
      if (sgn && n < 4 && ((v >> (8 * n - 1)) & 32'd1) == 32'd1) v = v | ~mask;
      return v;
   endfunction

   // One access: ready arrives in request-cycle index 'delay' (0 = the IDLE cycle).
   task automatic run_access(input string tag, input logic rd, input logic wr,
                             input logic [1:0] bhw, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rdv, input int delay, input bit gap);
      int  n, stalls, exp_stalls;
      bit  bad, tmo, req_seen;
      n = nbytes(bhw);
      bad = (rd && wr) || ((addr % n) != 0);
      tmo = !bad && (delay > T);
      exp_stalls = bad ? 1 : (tmo ? 1 + T : 1 + delay);

      @(negedge clk);
      bus.MemRead_in = rd;  bus.MemWrite_in = wr;  bus.BHW_in = bhw;
      bus.DataMemExtendSign_in = sgn;  bus.Addr_in = addr;  bus.WriteData_in = wd;
      bus.mem_rdata = rdv;  bus.mem_ready = (delay == 0);
      #1;
      chk({tag, ".req0"}, bus.mem_req, !bad);
      if (!bad) begin
         chk({tag, ".be"},    bus.mem_be,    m_be(bhw, addr));
         chk({tag, ".wdata"}, bus.mem_wdata, m_wdata(bhw, wd));
         chk({tag, ".addr"},  bus.mem_addr,  addr & 32'hFFFF_FFFC);
         chk({tag, ".we"},    bus.mem_we,    wr);
      end
      stalls = 0;
      req_seen = 0;
      while (bus.Stall_out === 1'b1 && stalls < 300) begin
         if (bus.mem_req === 1'b1) req_seen = 1;
         stalls++;
         @(negedge clk);
         bus.mem_ready = (stalls == delay);
         #1;
      end
      if (bad || tmo) model_rd = 32'd0;
      else if (rd) model_rd = m_load(bhw, addr, sgn, rdv);
      chk({tag, ".stalls"},  stalls,           exp_stalls);
      chk({tag, ".reqseen"}, req_seen,         !bad);
      chk({tag, ".fault"},   bus.Fault_out,    bad || tmo);
      chk({tag, ".rdata"},   bus.ReadData_out, model_rd);
      chk({tag, ".reqend"},  bus.mem_req,      1'b0);
      if (gap) begin
         @(negedge clk);
         bus.MemRead_in = 1'b0;  bus.MemWrite_in = 1'b0;
         bus.mem_ready = 1'($urandom_range(0, 1));
         #1;
         chk({tag, ".gapreq"},   bus.mem_req,      1'b0);
         chk({tag, ".gapstall"}, bus.Stall_out,    1'b0);
         chk({tag, ".gapfault"}, bus.Fault_out,    1'b0);
         chk({tag, ".gaprd"},    bus.ReadData_out, model_rd);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.MemRead_in = 1'b1;  bus.MemWrite_in = 1'b0;  bus.BHW_in = 2'b00;
      bus.DataMemExtendSign_in = 1'b0;  bus.Addr_in = 32'h100;  bus.WriteData_in = 32'h0;
      bus.mem_ready = 1'b1;  bus.mem_rdata = 32'hFFFF_FFFF;
      repeat (2) @(negedge clk);
      #1;
      chk("rst.req",   bus.mem_req,      1'b0);
      chk("rst.stall", bus.Stall_out,    1'b0);
      chk("rst.fault", bus.Fault_out,    1'b0);
      chk("rst.rd",    bus.ReadData_out, 32'd0);
      chk("rst.be",    bus.mem_be,       4'd0);
      chk("rst.we",    bus.mem_we,       1'b0);
      @(negedge clk);
      rst = 1'b0;  bus.MemRead_in = 1'b0;  bus.mem_ready = 1'b0;

      run_access("wload",  1, 0, 2'b00, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 1);
      run_access("bload_s",1, 0, 2'b10, 1, 32'h103, 32'h0,        32'h80123456, 0, 1);
      run_access("bload_z",1, 0, 2'b10, 0, 32'h103, 32'h0,        32'h80123456, 1, 1);
      run_access("hstore", 0, 1, 2'b01, 0, 32'h102, 32'h1234ABCD, 32'h0,        3, 1);
      run_access("tmo",    1, 0, 2'b00, 0, 32'h200, 32'h0,        32'h11111111, 50, 1);
      run_access("misal",  1, 0, 2'b00, 0, 32'h101, 32'h0,        32'h0,        0, 1);
      run_access("illeg",  1, 1, 2'b00, 0, 32'h100, 32'h0,        32'h0,        0, 1);
      run_access("b2b_a",  1, 0, 2'b01, 1, 32'h2, 32'h0,          32'h8001_7F00, 2, 0);
      run_access("b2b_b",  0, 1, 2'b11, 0, 32'h40, 32'hCAFEF00D,  32'h0,        4, 1);

      for (int i = 0; i < 80; i++) begin
         logic rd, wr;
         int sel = $urandom_range(0, 9);
         rd = (sel < 5) || (sel == 9);
         wr = (sel >= 5);
         run_access("rand", rd, wr, 2'($urandom), 1'($urandom), $urandom, $urandom,
                    $urandom, $urandom_range(0, 6), 1'($urandom));
      end

      // Reset in the 2nd WAIT cycle, together with mem_ready, abandons the load.
      run_access("preload", 1, 0, 2'b00, 0, 32'h300, 32'h0, 32'h12345678, 0, 1);
      @(negedge clk);
      bus.MemRead_in = 1'b1;  bus.MemWrite_in = 1'b0;  bus.BHW_in = 2'b00;
      bus.Addr_in = 32'h400;  bus.mem_rdata = 32'hA5A5A5A5;  bus.mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;  bus.mem_ready = 1'b1;
      #1;
      chk("rstw.req",   bus.mem_req,   1'b0);
      chk("rstw.stall", bus.Stall_out, 1'b0);
      @(negedge clk);
      rst = 1'b0;  bus.MemRead_in = 1'b0;  bus.mem_ready = 1'b1;
      #1;
      chk("rstw.req1",   bus.mem_req,      1'b0);
      chk("rstw.stall1", bus.Stall_out,    1'b0);
      chk("rstw.rd1",    bus.ReadData_out, 32'd0);
      @(negedge clk);
      bus.mem_ready = 1'b0;
      #1;
      chk("rstw.fault2", bus.Fault_out,    1'b0);
      chk("rstw.rd2",    bus.ReadData_out, 32'd0);
      chk("rstw.stall2", bus.Stall_out,    1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
